// File: rtl/tff_pkg.sv
// tff_pkg: state encoding and widths shared by the T flip-flop counter blocks
package tff_pkg;
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_HOLD = 2'd2} state_t;
    localparam int WRAP_CNT_W = 8;
endpackage

// File: rtl/tff_cell.sv
// tff_cell: single T flip-flop with asynchronous active-low reset
module tff_cell (
    input  logic t,
    input  logic clk,
    input  logic rst,
    output logic q
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) q <= 1'b0;
        else q <= q ^ t;
    end
endmodule

// File: rtl/tff_count_ctrl.sv
// tff_count_ctrl: start/stop/hold sequencer driving a bank of T flip-flops as a
// modulo-MODULO up/down counter with optional auto-stop after NWRAP wraps
module tff_count_ctrl
    import tff_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int MODULO = 10,
    parameter int NWRAP  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] t_vec,
    output logic             tc,
    output logic             busy,
    output logic             done
);
    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULO - 1);
    state_t state, state_nxt;
    logic [WRAP_CNT_W-1:0] wrap_cnt;
    logic [WIDTH-1:0] q_cnt, q_nxt;
    logic at_end, wrap, last_wrap;
    assign at_end    = up_dn ? (q == MAX) : (q == '0);
    assign q_cnt     = at_end ? (up_dn ? '0 : MAX) : (up_dn ? q + WIDTH'(1) : q - WIDTH'(1));
    assign wrap      = (state == S_RUN) && !load && at_end;
    assign last_wrap = (NWRAP > 0) && wrap && (wrap_cnt == WRAP_CNT_W'(NWRAP - 1));
    assign q_nxt     = load ? ((load_val > MAX) ? MAX : load_val) : ((state == S_RUN) ? q_cnt : q);
    // Cells only toggle; forcing zero under reset keeps t_vec quiet while held
    assign t_vec     = rst ? (q ^ q_nxt) : '0;
    assign busy      = state != S_IDLE;
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start && !stop) state_nxt = S_RUN;
            S_RUN:   if (stop) state_nxt = S_HOLD; else if (last_wrap) state_nxt = S_IDLE;
            S_HOLD:  if (stop) state_nxt = S_IDLE; else if (start) state_nxt = S_RUN;
            default: state_nxt = S_IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            wrap_cnt <= '0;
            tc       <= 1'b0;
            done     <= 1'b0;
        end else begin
            state <= state_nxt;
            tc    <= wrap;
            done  <= last_wrap && !stop;
            if (state == S_IDLE && state_nxt == S_RUN) wrap_cnt <= '0;
            else if (wrap && wrap_cnt != '1) wrap_cnt <= wrap_cnt + 1'b1;
        end
    end
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        tff_cell u_cell (.t(t_vec[i]), .clk(clk), .rst(rst), .q(q[i]));
    end
endmodule

// File: tb/tb_tff_count_ctrl.sv
// tb_tff_count_ctrl: scoreboard bench for a free-running (NWRAP=0) and an
// auto-stopping (NWRAP=2) counter driven from the same controls
module tb_tff_count_ctrl;
    logic clk = 1'b0, rst = 1'b0;
    logic start = 1'b0, stop = 1'b0, up_dn = 1'b1, load = 1'b0;
    logic [3:0] load_val = '0;
    logic [3:0] q0, t0, q1, t1;
    logic tc0, busy0, done0, tc1, busy1, done1;

    tff_count_ctrl #(.WIDTH(4), .MODULO(10), .NWRAP(0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .up_dn(up_dn), .load(load),
        .load_val(load_val), .q(q0), .t_vec(t0), .tc(tc0), .busy(busy0), .done(done0));
    tff_count_ctrl #(.WIDTH(4), .MODULO(10), .NWRAP(2)) dut1 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .up_dn(up_dn), .load(load),
        .load_val(load_val), .q(q1), .t_vec(t1), .tc(tc1), .busy(busy1), .done(done1));

    always #5 clk = ~clk;

    typedef struct {int k; int q; logic tc; logic busy; logic done;} exp_t;
    exp_t sbq[$];
    int n_cmp = 0, n_bad = 0;
    int mq[2] = '{0, 0}, ms[2] = '{0, 0}, mw[2] = '{0, 0};
    int nw[2] = '{0, 2};

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mq[k] = 0; ms[k] = 0; mw[k] = 0;
        end
    endtask

    // One clock edge: predict both counters, check t_vec before the edge, outputs after
    task automatic step();
        exp_t e;
        #1;
        for (int k = 0; k < 2; k++) begin
            int nq, ns;
            bit wr, fin;
            wr = 0;
            ns = ms[k];
            if (load) nq = (load_val > 9) ? 9 : int'(load_val);
            else if (ms[k] == 1) begin
                wr = up_dn ? (mq[k] == 9) : (mq[k] == 0);
                nq = up_dn ? ((mq[k] == 9) ? 0 : mq[k] + 1) : ((mq[k] == 0) ? 9 : mq[k] - 1);
            end else nq = mq[k];
            fin = wr && nw[k] > 0 && mw[k] == nw[k] - 1;
            if (ms[k] == 0) begin
                if (start && !stop) ns = 1;
            end else if (ms[k] == 1) begin
                if (stop) ns = 2; else if (fin) ns = 0;
            end else begin
                if (stop) ns = 0; else if (start) ns = 1;
            end
            check(k ? "t_vec1" : "t_vec0", k ? int'(t1) : int'(t0), mq[k] ^ nq);
            e.k = k; e.q = nq; e.tc = wr; e.busy = ns != 0; e.done = fin && !stop;
            sbq.push_back(e);
            if (ms[k] == 0 && ns == 1) mw[k] = 0;
            else if (wr && mw[k] < 255) mw[k]++;
            mq[k] = nq;
            ms[k] = ns;
        end
        @(posedge clk);
        #1;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            check(e.k ? "q1" : "q0", e.k ? int'(q1) : int'(q0), e.q);
            check(e.k ? "tc1" : "tc0", e.k ? int'(tc1) : int'(tc0), int'(e.tc));
            check(e.k ? "busy1" : "busy0", e.k ? int'(busy1) : int'(busy0), int'(e.busy));
            check(e.k ? "done1" : "done0", e.k ? int'(done1) : int'(done0), int'(e.done));
            check("q_range", int'((e.k ? q1 : q0) < 4'd10), 1);
        end
    endtask

    initial begin
        int n;
        #12;
        check("rst_q", int'(q0), 0);
        check("rst_busy", int'(busy0), 0);
        check("rst_tc", int'(tc0), 0);
        check("rst_done", int'(done1), 0);
        check("rst_t", int'(t0), 0);
        @(negedge clk) rst = 1'b1;
        // up count and wrap
        start = 1'b1; up_dn = 1'b1;
        step();
        check("start_no_count", int'(q0), 0);
        start = 1'b0;
        n = 0;
        while (mq[0] != 9 && n < 20) begin
            step();
            n++;
        end
        check("edges_to_9", n, 9);
        check("q_at_9", int'(q0), 9);
        #1 check("t_9to0", int'(t0), 4'b1001);
        step();
        check("wrap_q", int'(q0), 0);
        check("wrap_tc", int'(tc0), 1);
        step();
        check("tc_one_cycle", int'(tc0), 0);
        // down count with load
        load_val = 4'd2; load = 1'b1; up_dn = 1'b0;
        step();
        check("load2", int'(q0), 2);
        load = 1'b0;
        step(); check("down1", int'(q0), 1);
        step(); check("down0", int'(q0), 0);
        step(); check("down_wrap", int'(q0), 9);
        check("down_tc", int'(tc0), 1);
        load_val = 4'd15; load = 1'b1;
        step();
        check("load_clamp", int'(q0), 9);
        check("load_no_tc", int'(tc0), 0);
        load = 1'b0; up_dn = 1'b1;
        // hold and resume
        n = 0;
        while (mq[0] != 4 && n < 20) begin
            step();
            n++;
        end
        stop = 1'b1;
        step();
        check("hold_q", int'(q0), 5);
        stop = 1'b0;
        repeat (4) begin
            #1 check("hold_t", int'(t0), 0);
            step();
            check("hold_stay", int'(q0), 5);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        step(); check("resume6", int'(q0), 6);
        step(); check("resume7", int'(q0), 7);
        stop = 1'b1;
        step(); step();
        stop = 1'b0;
        check("idle_busy", int'(busy0), 0);
        // start and stop together
        start = 1'b1; stop = 1'b1;
        step();
        check("both_idle", int'(busy0), 0);
        stop = 1'b0;
        step();
        stop = 1'b1;
        step();
        check("both_run_hold", int'(busy0), 1);
        step();
        start = 1'b0; stop = 1'b0;
        check("back_idle", int'(busy0), 0);
        // auto-stop after two wraps
        load_val = 4'd0; load = 1'b1;
        step();
        load = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (ms[1] == 1 && n < 40) begin
            step();
            n++;
        end
        check("auto_edges", n, 20);
        check("auto_done", int'(done1), 1);
        check("auto_tc", int'(tc1), 1);
        check("auto_busy", int'(busy1), 0);
        check("auto_q", int'(q1), 0);
        step();
        check("auto_done_pulse", int'(done1), 0);
        check("auto_q_hold", int'(q1), 0);
        // asynchronous reset mid-run
        load_val = 4'd7; load = 1'b1;
        step();
        load = 1'b0;
        check("pre_rst_q", int'(q0), 7);
        #2 rst = 1'b0;
        load_val = 4'd5; load = 1'b1;
        #1;
        check("arst_q", int'(q0), 0);
        check("arst_busy", int'(busy0), 0);
        check("arst_tc", int'(tc0), 0);
        check("arst_t", int'(t0), 0);
        load = 1'b0;
        model_reset();
        @(negedge clk) rst = 1'b1;
        step();
        check("post_rst_idle", int'(busy0), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
